wrb_port_scheduler: RTL
=======================

// Module: wrb_port_scheduler
// PURPOSE
//  Writeback-side transmitter for the physical register file's two write ports.
//  Accepts results from NUM_SRC execution units (alu1, alu2, lsu, md, falu1, falu2, fdivsqrt).
//  Each unit presents a valid/ready handshake; the block buffers one result per unit.
//  Each cycle it issues up to two results, round-robin, as registered first/second write requests.
//  Units stall when their buffer is held, so results are never lost when more than two arrive at once.
// PARAMETERS
//  NUM_SRC          7    number of writeback sources
//  REG_SIZE_WIDTH   7    physical register address width
//  XLEN             64   data width
// PORTS
//  clk                 in   1                      single clock, rising edge
//  rst_n               in   1                      asynchronous, active-low reset
//  src_valid_i         in   NUM_SRC                source i presents a result
//  src_ready_o         out  NUM_SRC                source i result accepted this cycle
//  src_address_i       in   NUM_SRC*REG_SIZE_WIDTH destination preg, packed, src0 in LSBs
//  src_data_i          in   NUM_SRC*XLEN           result data, packed
//  wr_first_valid_o    out  1                      write port 0 request
//  wr_first_address_o  out  REG_SIZE_WIDTH         write port 0 preg
//  wr_first_data_o     out  XLEN                   write port 0 data
//  wr_second_valid_o   out  1                      write port 1 request
//  wr_second_address_o out  REG_SIZE_WIDTH         write port 1 preg
//  wr_second_data_o    out  XLEN                   write port 1 data
// BEHAVIOUR
//  Reset (rst_n=0, async): all hold entries empty; rr pointer=0; all wr_* outputs 0.
//   src_ready_o=0 while in reset.
//  Hold entry per source: {vld, addr, data}.
//   src_ready_o[i] = !hold[i].vld | granted[i] (combinational).
//   Transfer on src_valid_i[i] & src_ready_o[i]: entry loads on the next edge.
//  Pick: among held entries, first two in rr order starting at pointer.
//   first = lowest rr distance; second = next.
//   Second is skipped (stays held) if its addr == first's addr.
//  Grant: picked entries clear, or reload if the same source transfers a new result that cycle.
//   wr_first_*/wr_second_* are registered from the picks on the next edge.
//   wr_*_valid_o=0 when there is no pick; address and data then hold their previous values.
//  Only one pick -> it drives the first port; wr_second_valid_o=0.
//  Pointer update: set to (index of last granted source + 1) mod NUM_SRC; unchanged if no grant.
//  Preg 0: a transfer with addr==0 is acked and discarded, never held or written (P0 fixed at 0).
//  Latency (no macro): src handshake at cycle T -> held at T+1 -> earliest wr_* valid at T+2.
//  Throughput: 2 results/cycle sustained.
//  Starvation bound: any held entry issues within ceil(NUM_SRC/2) cycles.
//  Same-addr sources in flight together are illegal upstream; the block only serializes them.
// CONFIGURATION
//  WRB_BYPASS_EN defined:
//   an empty-hold source with src_valid_i joins the same-cycle pick.
//   It ranks behind all held entries, then in rr order.
//   If picked, it is not stored; the handshake at T gives wr_* valid at T+1.
//  WRB_BYPASS_EN undefined: every result passes through its hold entry (2-cycle minimum latency).
// STRUCTURE
//  Package rcu_wrb_pkg:
//   wrb_entry_t struct {logic vld; logic [REG_SIZE_WIDTH-1:0] addr; logic [XLEN-1:0] data}.
//   Source index localparams: ALU1=0, ALU2=1, LSU=2, MD=3, FALU1=4, FALU2=5, FDIVSQRT=6.
//  Sub-module rr_pick2:
//   input request vector + pointer; outputs two one-hot grants with valid.
//   Purely combinational; it handles the address-conflict skip via a pairwise-equality input.
// TESTING
//  1. Single ALU1 result addr=5 data=0xDEAD, no macro.
//     -> ready=1; wr_first valid at T+2 with 5/0xDEAD; second port idle.
//  2. All 7 sources valid in one cycle, addrs 1..7, pointer=0.
//     -> issue order {1,2},{3,4},{5,6},{7}; each source stalls until its entry drains.
//  3. ALU1 and LSU both held with addr=9.
//     -> ALU1 issues first; LSU issues alone on the next cycle; no dual write to 9.
//  4. MD result with addr=0.
//     -> ready=1; no wr_* valid ever results; hold entry stays empty.
//  5. rst_n asserted low mid-burst with 3 entries held.
//     -> outputs 0 immediately; entries drop; no writes after release.
//  6. WRB_BYPASS_EN, FALU1 alone, addr=12.
//     -> wr_first valid at T+1; with 2 entries already held, FALU1 waits one cycle.

Source files
------------

// File: rtl/rcu_wrb_pkg.sv
// Shared types and constants for the writeback port scheduler.
// Source indices, hold-entry layout and round-robin pointer helper.
package rcu_wrb_pkg;

    localparam int NUM_SRC        = 7;
    localparam int REG_SIZE_WIDTH = 7;
    localparam int XLEN           = 64;
    localparam int PTR_W          = $clog2(NUM_SRC);

    localparam int ALU1     = 0;
    localparam int ALU2     = 1;
    localparam int LSU      = 2;
    localparam int MD       = 3;
    localparam int FALU1    = 4;
    localparam int FALU2    = 5;
    localparam int FDIVSQRT = 6;

    typedef struct packed {
        logic                      vld;
        logic [REG_SIZE_WIDTH-1:0] addr;
        logic [XLEN-1:0]           data;
    } wrb_entry_t;

    function automatic logic [PTR_W-1:0] rr_next(
        input logic [PTR_W-1:0] idx
    );
        if (idx == PTR_W'(NUM_SRC - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// Held requests rank ahead of low-priority ones; same-address second pick is dropped.
module rr_pick2
    import rcu_wrb_pkg::*;
(
    input  logic [NUM_SRC-1:0]         req_i,
    input  logic [NUM_SRC-1:0]         low_i,
    input  logic [PTR_W-1:0]           ptr_i,
    input  logic [NUM_SRC*NUM_SRC-1:0] eq_i,
    output logic                       first_vld_o,
    output logic [NUM_SRC-1:0]         first_oh_o,
    output logic [PTR_W-1:0]           first_idx_o,
    output logic                       second_vld_o,
    output logic [NUM_SRC-1:0]         second_oh_o,
    output logic [PTR_W-1:0]           second_idx_o
);

    logic [PTR_W-1:0] idx;
    logic             lo;
    logic             cand_vld;
    logic [PTR_W-1:0] cand_idx;
    int               eq_bit;

    // Walk held entries in rr order, then low-priority ones, taking the first two.
    always_comb begin
        first_vld_o = 1'b0;
        first_idx_o = '0;
        cand_vld    = 1'b0;
        cand_idx    = '0;
        idx         = ptr_i;
        lo          = 1'b0;
        for (int k = 0; k < 2 * NUM_SRC; k++) begin
            lo = (k >= NUM_SRC);
            if (req_i[idx] && (low_i[idx] == lo)) begin
                if (!first_vld_o) begin
                    first_vld_o = 1'b1;
                    first_idx_o = idx;
                end else if (!cand_vld) begin
                    cand_vld = 1'b1;
                    cand_idx = idx;
                end
            end
            idx = rr_next(idx);
        end
    end

    // Suppress the second grant when it would write the same preg as the first.
    always_comb begin
        eq_bit       = int'(first_idx_o) * NUM_SRC + int'(cand_idx);
        second_vld_o = cand_vld && !eq_i[eq_bit];
        second_idx_o = cand_idx;
        first_oh_o   = '0;
        second_oh_o  = '0;
        if (first_vld_o) begin
            first_oh_o = NUM_SRC'(1) << first_idx_o;
        end
        if (second_vld_o) begin
            second_oh_o = NUM_SRC'(1) << cand_idx;
        end
    end

endmodule

// File: rtl/wrb_port_scheduler.sv
// Buffers one result per writeback source and issues up to two per cycle.
// Optional same-cycle bypass of empty entries: define WRB_BYPASS_EN.
module wrb_port_scheduler
    import rcu_wrb_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SRC-1:0]                src_valid_i,
    output logic [NUM_SRC-1:0]                src_ready_o,
    input  logic [NUM_SRC*REG_SIZE_WIDTH-1:0] src_address_i,
    input  logic [NUM_SRC*XLEN-1:0]           src_data_i,
    output logic                              wr_first_valid_o,
    output logic [REG_SIZE_WIDTH-1:0]         wr_first_address_o,
    output logic [XLEN-1:0]                   wr_first_data_o,
    output logic                              wr_second_valid_o,
    output logic [REG_SIZE_WIDTH-1:0]         wr_second_address_o,
    output logic [XLEN-1:0]                   wr_second_data_o
);

    wrb_entry_t hold_q [NUM_SRC];
    wrb_entry_t hold_d [NUM_SRC];

    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic                      wr_first_valid_q, wr_first_valid_d;
    logic [REG_SIZE_WIDTH-1:0] wr_first_address_q, wr_first_address_d;
    logic [XLEN-1:0]           wr_first_data_q, wr_first_data_d;
    logic                      wr_second_valid_q, wr_second_valid_d;
    logic [REG_SIZE_WIDTH-1:0] wr_second_address_q, wr_second_address_d;
    logic [XLEN-1:0]           wr_second_data_q, wr_second_data_d;

    logic [REG_SIZE_WIDTH-1:0] in_addr [NUM_SRC];
    logic [XLEN-1:0]           in_data [NUM_SRC];
    logic [REG_SIZE_WIDTH-1:0] cand_addr [NUM_SRC];
    logic [XLEN-1:0]           cand_data [NUM_SRC];

    logic [NUM_SRC-1:0]         held;
    logic [NUM_SRC-1:0]         byp;
    logic [NUM_SRC-1:0]         req;
    logic [NUM_SRC*NUM_SRC-1:0] eq;
    logic [NUM_SRC-1:0]         granted;
    logic [NUM_SRC-1:0]         xfer;

    logic                       first_vld, second_vld;
    logic [NUM_SRC-1:0]         first_oh, second_oh;
    logic [PTR_W-1:0]           first_idx, second_idx;

    // Unpack sources and form the candidate set seen by the picker.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_addr[i] = src_address_i[i*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
            in_data[i] = src_data_i[i*XLEN +: XLEN];
            held[i]    = hold_q[i].vld;
`ifdef WRB_BYPASS_EN
            byp[i]     = !hold_q[i].vld && src_valid_i[i] && (in_addr[i] != '0);
`else
            byp[i]     = 1'b0;
`endif
            req[i]       = held[i] | byp[i];
            cand_addr[i] = held[i] ? hold_q[i].addr : in_addr[i];
            cand_data[i] = held[i] ? hold_q[i].data : in_data[i];
        end
    end

    // Pairwise destination equality for the conflict skip.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                eq[i*NUM_SRC + j] = (cand_addr[i] == cand_addr[j]);
            end
        end
    end

    rr_pick2 u_pick (
        .req_i        (req),
        .low_i        (byp),
        .ptr_i        (ptr_q),
        .eq_i         (eq),
        .first_vld_o  (first_vld),
        .first_oh_o   (first_oh),
        .first_idx_o  (first_idx),
        .second_vld_o (second_vld),
        .second_oh_o  (second_oh),
        .second_idx_o (second_idx)
    );

    // A source may hand over a result whenever its entry is free or draining.
    always_comb begin
        granted     = first_oh | second_oh;
        src_ready_o = rst_n ? (~held | granted) : '0;
        xfer        = src_valid_i & src_ready_o;
    end

    // Entry update: drain on grant, load on transfer, drop P0 and bypassed results.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            hold_d[i] = hold_q[i];
            if (granted[i]) begin
                hold_d[i].vld = 1'b0;
            end
            if (xfer[i] && (in_addr[i] != '0) && !(granted[i] && !held[i])) begin
                hold_d[i].vld  = 1'b1;
                hold_d[i].addr = in_addr[i];
                hold_d[i].data = in_data[i];
            end
        end
    end

    // Next pointer and next write-port requests.
    always_comb begin
        ptr_d               = ptr_q;
        wr_first_valid_d    = first_vld;
        wr_first_address_d  = wr_first_address_q;
        wr_first_data_d     = wr_first_data_q;
        wr_second_valid_d   = second_vld;
        wr_second_address_d = wr_second_address_q;
        wr_second_data_d    = wr_second_data_q;
        if (first_vld) begin
            ptr_d              = rr_next(first_idx);
            wr_first_address_d = cand_addr[first_idx];
            wr_first_data_d    = cand_data[first_idx];
        end
        if (second_vld) begin
            ptr_d               = rr_next(second_idx);
            wr_second_address_d = cand_addr[second_idx];
            wr_second_data_d    = cand_data[second_idx];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_q[i] <= '0;
            end
            ptr_q               <= '0;
            wr_first_valid_q    <= 1'b0;
            wr_first_address_q  <= '0;
            wr_first_data_q     <= '0;
            wr_second_valid_q   <= 1'b0;
            wr_second_address_q <= '0;
            wr_second_data_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_q[i] <= hold_d[i];
            end
            ptr_q               <= ptr_d;
            wr_first_valid_q    <= wr_first_valid_d;
            wr_first_address_q  <= wr_first_address_d;
            wr_first_data_q     <= wr_first_data_d;
            wr_second_valid_q   <= wr_second_valid_d;
            wr_second_address_q <= wr_second_address_d;
            wr_second_data_q    <= wr_second_data_d;
        end
    end

    assign wr_first_valid_o    = wr_first_valid_q;
    assign wr_first_address_o  = wr_first_address_q;
    assign wr_first_data_o     = wr_first_data_q;
    assign wr_second_valid_o   = wr_second_valid_q;
    assign wr_second_address_o = wr_second_address_q;
    assign wr_second_data_o    = wr_second_data_q;

endmodule
